// File: rtl/wb_pkg.sv
// Shared constants and the writeback entry type for the register file write front end.
package wb_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending writebacks; all slots and valid bits are
// exported so the parent can search them for forwarding.
module wb_fifo #(
  parameter int DEPTH = wb_pkg::DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  wb_pkg::wb_entry_t             push_entry,
  input  logic                          pop,
  output wb_pkg::wb_entry_t             head_entry,
  output wb_pkg::wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]              valid,
  output logic [PTR_W-1:0]              head,
  output logic [CNT_W-1:0]              count
);
  import wb_pkg::*;

  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  // Guards make the buffer safe on its own even if a caller ignores count.
  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    ent_d   = ent_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (do_pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    if (do_push) begin
      ent_d[tail_q] = push_entry;
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_entry = ent_q[head_q];
  assign entries    = ent_q;
  assign valid      = vld_q;
  assign head       = head_q;
  assign count      = count_q;
endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates ALU/load writebacks into an in-order FIFO, retires one write per
// cycle to the register file and forwards the newest pending value per read port.
module wb_write_arbiter #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DEPTH  = wb_pkg::DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     wr,
  output logic [ADDR_W-1:0]        rd,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        r1,
  input  logic [ADDR_W-1:0]        r2,
  output logic                     fwd1_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);
  import wb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t             push_entry, head_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      head;
  logic [CNT_W-1:0]      count_w;
  logic                  full, mem_fire, alu_fire, push, pop;

  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     rd_q, rd_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  // Full comes from the registered count only, so ready never depends on pop.
  assign full      = (count_w == CNT_W'(DEPTH));
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign pop       = (count_w != '0);

  always_comb begin
    push_entry = '{rd: alu_rd, data: alu_data};
    push       = alu_fire && (alu_rd != '0);
    if (mem_fire) begin
      push_entry = '{rd: mem_rd, data: mem_data};
      push       = (mem_rd != '0);
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid),
    .head       (head),
    .count      (count_w)
  );

  always_comb begin
    wr_d    = pop;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (pop) begin
      rd_d    = head_entry.rd;
      wdata_d = head_entry.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

  assign wr         = wr_q;
  assign rd         = rd_q;
  assign write_data = wdata_q;
  assign count      = count_w;

  // Walk head..tail so later (younger) matches override older ones and the output register.
  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0]             hit;
  logic [1:0][DATA_W-1:0] fdata;
  logic [PTR_W-1:0]       idx;

  assign raddr = {r2, r1};

  always_comb begin
    hit   = '0;
    fdata = '0;
    idx   = '0;
    for (int p = 0; p < 2; p++) begin
      if (wr_q && (rd_q == raddr[p])) begin
        hit[p]   = 1'b1;
        fdata[p] = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if (valid[idx] && (entries[idx].rd == raddr[p])) begin
          hit[p]   = 1'b1;
          fdata[p] = entries[idx].data;
        end
      end
      if (raddr[p] == '0) begin
        hit[p]   = 1'b0;
        fdata[p] = '0;
      end
    end
  end

  assign fwd1_hit  = hit[0];
  assign fwd1_data = fdata[0];
  assign fwd2_hit  = hit[1];
  assign fwd2_data = fdata[1];
endmodule
